// File: rtl/enigma_pkg.sv
// Shared constants for the reflector configuration path: alphabet geometry,
// error codes and the loader state encoding.
package enigma_pkg;

    localparam int N_LETTERS = 26;
    localparam int CHAR_W    = 8;
    localparam int BASE_CHAR = 65;
    localparam int IDX_W     = N_LETTERS * CHAR_W;
    localparam int CNT_W     = 5;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_SELF  = 2'd2;
    localparam logic [1:0] ERR_INV   = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    function automatic logic is_letter(input logic [CHAR_W-1:0] c);
        return (c >= CHAR_W'(BASE_CHAR)) && (c <= CHAR_W'(BASE_CHAR + N_LETTERS - 1));
    endfunction

endpackage

// File: rtl/refl_pair_check.sv
// Combinational test of one table index i: flags a letter wired to itself,
// or a pairing that is not reciprocated (table[table[i]] != i).
module refl_pair_check
    import enigma_pkg::*;
(
    input  logic [IDX_W-1:0] shadow,
    input  logic [CNT_W-1:0] i,
    output logic             self_map,
    output logic             not_inv
);

    logic [0:N_LETTERS-1][CHAR_W-1:0] tbl;
    logic [CHAR_W-1:0] ent_i;
    logic [CHAR_W-1:0] ent_m;
    logic [CHAR_W-1:0] want;
    logic [CNT_W-1:0]  m;

    assign tbl = shadow;

    // Explicit mux loops keep the 5-bit indices from ever addressing past entry 25.
    always_comb begin
        ent_i = '0;
        ent_m = '0;
        for (int j = 0; j < N_LETTERS; j++) begin
            if (i == CNT_W'(j)) ent_i = tbl[j];
        end
        m = CNT_W'(ent_i - CHAR_W'(BASE_CHAR));
        for (int j = 0; j < N_LETTERS; j++) begin
            if (m == CNT_W'(j)) ent_m = tbl[j];
        end
        want     = CHAR_W'(BASE_CHAR) + CHAR_W'(i);
        self_map = (m == i);
        not_inv  = (ent_m != want);
    end

endmodule

// File: rtl/reflector_cfg_loader.sv
// Loads a 26-letter reflector wiring from a byte stream, validates it, and
// publishes it on idx_out with a set pulse only when the whole table is legal.
//
// state  | meaning
// IDLE   | waiting for cfg_start
// LOAD   | accepting bytes into the shadow buffer
// CHECK  | verifying one index per cycle (self-map, then involution)
// COMMIT | copy shadow to idx_out, pulse set and done
// ERROR  | pulse done, raise err with the captured code
module reflector_cfg_loader
    import enigma_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_start,
    input  logic               cfg_valid,
    input  logic [CHAR_W-1:0]  cfg_din,
    output logic               cfg_ready,
    output logic               set,
    output logic [IDX_W-1:0]   idx_out,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code
);

    logic [2:0]                       state;
    logic [CNT_W-1:0]                 count;
    logic [0:N_LETTERS-1][CHAR_W-1:0] shadow_q;
    logic [1:0]                       pend_code;
    logic                             self_map;
    logic                             not_inv;

    refl_pair_check u_pair_check (
        .shadow   (shadow_q),
        .i        (count),
        .self_map (self_map),
        .not_inv  (not_inv)
    );

    assign busy = (state == ST_LOAD) || (state == ST_CHECK) || (state == ST_COMMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            shadow_q  <= '0;
            idx_out   <= '0;
            set       <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            pend_code <= ERR_NONE;
            cfg_ready <= 1'b0;
        end else begin
            set  <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // done high means the previous load is finishing this cycle
                    if (cfg_start && !done) begin
                        state     <= ST_LOAD;
                        count     <= '0;
                        err       <= 1'b0;
                        err_code  <= ERR_NONE;
                        cfg_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (cfg_valid && cfg_ready) begin
                        if (!is_letter(cfg_din)) begin
                            state     <= ST_ERROR;
                            pend_code <= ERR_RANGE;
                            cfg_ready <= 1'b0;
                        end else begin
                            for (int j = 0; j < N_LETTERS; j++) begin
                                if (count == CNT_W'(j)) shadow_q[j] <= cfg_din;
                            end
                            if (count == CNT_W'(N_LETTERS - 1)) begin
                                state     <= ST_CHECK;
                                count     <= '0;
                                cfg_ready <= 1'b0;
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    if (self_map) begin
                        state     <= ST_ERROR;
                        pend_code <= ERR_SELF;
                    end else if (not_inv) begin
                        state     <= ST_ERROR;
                        pend_code <= ERR_INV;
                    end else if (count == CNT_W'(N_LETTERS - 1)) begin
                        state <= ST_COMMIT;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    idx_out <= shadow_q;
                    set     <= 1'b1;
                    done    <= 1'b1;
                    state   <= ST_IDLE;
                end
                ST_ERROR: begin
                    done     <= 1'b1;
                    err      <= 1'b1;
                    err_code <= pend_code;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reflector_cfg_loader.sv
// Directed bench for reflector_cfg_loader: each load pushes its expected outcome
// to a scoreboard that is popped and compared when done pulses.
module tb_reflector_cfg_loader;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cfg_start = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [7:0]   cfg_din = 8'h00;
    logic         cfg_ready;
    logic         set;
    logic [207:0] idx_out;
    logic         busy;
    logic         done;
    logic         err;
    logic [1:0]   err_code;

    typedef struct {
        logic [1:0]   code;
        logic [207:0] idx;
        int           done_cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           set_count = 0;
    int           k = 0;
    int           sc = 0;
    logic [7:0]   tbl [26];
    logic [207:0] model_idx = '0;
    string        ukwb = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    reflector_cfg_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_din   (cfg_din),
        .cfg_ready (cfg_ready),
        .set       (set),
        .idx_out   (idx_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [207:0] obs, input logic [207:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ukwb();
        for (int i = 0; i < 26; i++) tbl[i] = ukwb[i];
    endtask

    function automatic logic [207:0] pack_tbl();
        logic [207:0] p;
        p = '0;
        for (int i = 0; i < 26; i++) p[207-8*i -: 8] = tbl[i];
        return p;
    endfunction

    // Sends tbl[0..last]; expects outcome 'code' with done lat cycles after the last transfer.
    task automatic run_load(input logic [1:0] code, input int lat, input bit gaps,
                            input bit starts, input int last);
        int   idx;
        int   budget;
        bit   v;
        logic r;
        exp_t e;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("start_err_clr", err, 1'b0);
        check("start_code_clr", err_code, 2'd0);
        check("start_ready", cfg_ready, 1'b1);
        idx = 0;
        budget = 0;
        while (idx <= last && budget < 400) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            cfg_valid = v;
            cfg_din   = tbl[idx];
            cfg_start = starts && ($urandom_range(0, 4) == 0);
            r = cfg_ready;
            tick();
            budget++;
            if (v && r === 1'b1) begin
                k = cyc;
                idx++;
            end
        end
        cfg_valid = 1'b0;
        cfg_start = 1'b0;
        check("load_budget", idx, last + 1);
        e.code     = code;
        e.idx      = (code == 2'd0) ? pack_tbl() : model_idx;
        e.done_cyc = k + lat;
        sb.push_back(e);
        if (code == 2'd0) model_idx = pack_tbl();
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        while (sb.size() != 0 && b < 100) begin
            tick();
            b++;
        end
        check("done_timeout", sb.size(), 0);
        tick();
    endtask

    always @(negedge clk) begin
        if (reset_n && set) set_count++;
        if (reset_n && done) begin
            check("sb_has_entry", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("done_cycle", cyc, mon_e.done_cyc);
                check("set_on_done", set, mon_e.code == 2'd0);
                check("err_on_done", err, mon_e.code != 2'd0);
                check("err_code", err_code, mon_e.code);
                check("idx_out", idx_out, mon_e.idx);
            end
        end
    end

    initial begin
        #1;
        check("rst_idx", idx_out, '0);
        check("rst_set", set, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_code", err_code, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cfg_ready, 1'b0);
        tick(); tick(); tick();
        reset_n = 1'b1;
        tick();

        // 1: clean UKW-B, no gaps
        load_ukwb();
        sc = set_count;
        run_load(2'd0, 27, 1'b0, 1'b0, 25);
        check("t1_busy_check", busy, 1'b1);
        check("t1_ready_low", cfg_ready, 1'b0);
        wait_done();
        check("t1_set_pulses", set_count - sc, 1);
        check("t1_byte_a", idx_out[207:200], 8'h59);
        check("t1_byte_b", idx_out[199:192], 8'h52);
        check("t1_byte_z", idx_out[7:0], 8'h54);
        check("t1_busy_idle", busy, 1'b0);

        // 2: same table with valid gaps and stray starts
        load_ukwb();
        sc = set_count;
        run_load(2'd0, 27, 1'b1, 1'b1, 25);
        wait_done();
        check("t2_set_pulses", set_count - sc, 1);
        check("t2_err", err, 1'b0);

        // 3: lowercase byte at index 3
        load_ukwb();
        tbl[3] = 8'h61;
        sc = set_count;
        run_load(2'd1, 1, 1'b0, 1'b0, 3);
        check("t3_ready_drop", cfg_ready, 1'b0);
        wait_done();
        check("t3_set_pulses", set_count - sc, 0);
        check("t3_err_level", err, 1'b1);

        // 4: A maps to itself
        load_ukwb();
        tbl[0] = 8'h41;
        sc = set_count;
        run_load(2'd2, 2, 1'b0, 1'b0, 25);
        wait_done();
        check("t4_set_pulses", set_count - sc, 0);

        // 5: B -> U breaks reciprocity, then a good reload
        load_ukwb();
        tbl[1] = 8'h55;
        sc = set_count;
        run_load(2'd3, 3, 1'b0, 1'b0, 25);
        wait_done();
        check("t5_set_pulses", set_count - sc, 0);
        check("t5_err_level", err, 1'b1);
        load_ukwb();
        sc = set_count;
        run_load(2'd0, 27, 1'b0, 1'b0, 25);
        wait_done();
        check("t5_reload_pulses", set_count - sc, 1);
        check("t5_reload_err", err, 1'b0);

        // 6: reset after 10 bytes
        load_ukwb();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cfg_valid = 1'b1;
            cfg_din   = tbl[i];
            tick();
        end
        cfg_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("t6_idx", idx_out, '0);
        check("t6_set", set, 1'b0);
        check("t6_done", done, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_ready", cfg_ready, 1'b0);
        check("t6_err", err, 1'b0);
        check("t6_code", err_code, 2'd0);
        tick(); tick();
        reset_n = 1'b1;
        model_idx = '0;
        tick();
        sc = set_count;
        run_load(2'd0, 27, 1'b0, 1'b0, 25);
        wait_done();
        check("t6_set_pulses", set_count - sc, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
